mpq_cmd_feeder: RTL and testbench

- Upstream stage of the MPQ priority-queue block; sits between a host-side packet source and MPQ's data/command inputs.
- Buffers host entries in a FIFO.
- Replays the entries as the MPQ input protocol: a contiguous data_valid burst first, then cmd_valid pulses gated by MPQ's busy.
- Enforces phase ordering and issue spacing so the host never has to track MPQ timing.

---
 rtl/mpq_cmd_feeder.sv | 149 ++++++++++++++
 tb/tb_mpq_cmd_feeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mpq_cmd_feeder.sv
// Host-side feeder for the MPQ priority queue: buffers host entries and replays
// them as a data_valid burst followed by busy-gated, spaced cmd_valid pulses.
module mpq_cmd_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic       host_type,
  input  logic [2:0] host_cmd,
  input  logic [7:0] host_index,
  input  logic [7:0] host_value,
  input  logic       host_last,
  input  logic       busy,
  output logic       data_valid,
  output logic [7:0] data,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic [7:0] index,
  output logic [7:0] value,
  output logic       seq_err,
  output logic       all_issued
);

  typedef enum logic [1:0] {S_DATA, S_CMD, S_END} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Entry layout: {type, last, cmd[2:0], index[7:0], value[7:0]}
  logic [20:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  logic          r_holdoff;
  logic          r_last_popped;
  logic          r_all_issued;
  logic          r_seq_err;

  logic          r_dvld_p1;
  logic [7:0]    r_data_p1;
  logic          r_cvld_p1;
  logic [2:0]    r_cmd_p1;
  logic [7:0]    r_index_p1;
  logic [7:0]    r_value_p1;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic [20:0]   w_head;
  logic          w_pop_data;
  logic          w_pop_cmd;
  logic          w_drop;
  logic          w_pop;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_push  = host_valid && !w_full;
  assign w_head  = r_mem[r_rptr];
  assign w_pop   = w_pop_data || w_pop_cmd || w_drop;

  // Pop decision works only from registered occupancy, so a same-cycle push is never seen.
  always_comb begin
    w_pop_data = 1'b0;
    w_pop_cmd  = 1'b0;
    w_drop     = 1'b0;
    case (r_state)
      S_DATA: begin
        if (!w_empty && !w_head[20]) w_pop_data = 1'b1;
      end
      S_CMD: begin
        if (!w_empty && !busy && !r_holdoff) begin
          if (w_head[20]) w_pop_cmd = 1'b1;
          else            w_drop    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {host_type, host_last, host_cmd, host_index, host_value};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_state       <= S_DATA;
      r_holdoff     <= 1'b0;
      r_last_popped <= 1'b0;
      r_all_issued  <= 1'b0;
      r_seq_err     <= 1'b0;
      r_dvld_p1     <= 1'b0;
      r_data_p1     <= '0;
      r_cvld_p1     <= 1'b0;
      r_cmd_p1      <= '0;
      r_index_p1    <= '0;
      r_value_p1    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase

      case (r_state)
        S_DATA: begin
          if (w_pop_data && w_head[19])   r_state <= S_END;
          else if (!w_empty && w_head[20]) r_state <= S_CMD;
        end
        S_CMD: begin
          if (w_pop && w_head[19]) r_state <= S_END;
        end
        default: ;
      endcase

      // Holdoff covers the cmd_valid cycle so commands are at least two cycles apart.
      r_holdoff     <= w_pop_cmd;
      r_last_popped <= w_pop && w_head[19];
      if (r_last_popped) r_all_issued <= 1'b1;
      if (w_drop)        r_seq_err    <= 1'b1;

      // Output stage p1: one cycle after the pop
      r_dvld_p1  <= w_pop_data;
      r_data_p1  <= w_pop_data ? w_head[7:0]   : 8'd0;
      r_cvld_p1  <= w_pop_cmd;
      r_cmd_p1   <= w_pop_cmd  ? w_head[18:16] : 3'd0;
      r_index_p1 <= w_pop_cmd  ? w_head[15:8]  : 8'd0;
      r_value_p1 <= w_pop_cmd  ? w_head[7:0]   : 8'd0;
    end
  end

  assign host_ready = !w_full;
  assign data_valid = r_dvld_p1;
  assign data       = r_data_p1;
  assign cmd_valid  = r_cvld_p1;
  assign cmd        = r_cmd_p1;
  assign index      = r_index_p1;
  assign value      = r_value_p1;
  assign seq_err    = r_seq_err;
  assign all_issued = r_all_issued;

endmodule

// File: tb/tb_mpq_cmd_feeder.sv
// Scoreboard bench for mpq_cmd_feeder: stimulus pushes expected outputs,
// a negedge monitor pops and compares whenever data_valid or cmd_valid is high.
module tb_mpq_cmd_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_valid;
  logic       host_ready;
  logic       host_type;
  logic [2:0] host_cmd;
  logic [7:0] host_index;
  logic [7:0] host_value;
  logic       host_last;
  logic       busy;
  logic       data_valid;
  logic [7:0] data;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [7:0] index;
  logic [7:0] value;
  logic       seq_err;
  logic       all_issued;

  mpq_cmd_feeder #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_ready(host_ready), .host_type(host_type),
    .host_cmd(host_cmd), .host_index(host_index), .host_value(host_value),
    .host_last(host_last), .busy(busy),
    .data_valid(data_valid), .data(data), .cmd_valid(cmd_valid), .cmd(cmd),
    .index(index), .value(value), .seq_err(seq_err), .all_issued(all_issued)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       kind;
    logic [2:0] cmd;
    logic [7:0] idx;
    logic [7:0] val;
  } exp_t;

  exp_t expq[$];
  int   dcyc[$];
  int   ccyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  exp_t e;
  always @(negedge clk) begin
    if (data_valid === 1'b0) check("data_idle_zero", {24'd0, data}, 32'd0);
    if (cmd_valid === 1'b0)
      check("cmd_idle_zero", {13'd0, cmd, index, value}, 32'd0);
    if (data_valid === 1'b1 || cmd_valid === 1'b1) begin
      check("valid_exclusive", {31'd0, data_valid & cmd_valid}, 32'd0);
      if (expq.size() == 0) begin
        check("unexpected_output", {3'd0, data_valid, cmd_valid, data, cmd, index, value}, 32'd0);
      end else begin
        e = expq.pop_front();
        if (e.kind == 1'b0) begin
          check("data_valid", {31'd0, data_valid}, 32'd1);
          check("data", {24'd0, data}, {24'd0, e.val});
          dcyc.push_back(cyc);
        end else begin
          check("cmd_valid", {31'd0, cmd_valid}, 32'd1);
          check("cmd", {29'd0, cmd}, {29'd0, e.cmd});
          check("index", {24'd0, index}, {24'd0, e.idx});
          check("value", {24'd0, value}, {24'd0, e.val});
          ccyc.push_back(cyc);
        end
      end
    end
  end

  task automatic push(input logic t, input logic [2:0] c, input logic [7:0] i,
                      input logic [7:0] v, input logic l, input bit expect_out);
    exp_t x;
    host_type  = t;
    host_cmd   = c;
    host_index = i;
    host_value = v;
    host_last  = l;
    host_valid = 1'b1;
    if (expect_out) begin
      x.kind = t;
      x.cmd  = c;
      x.idx  = i;
      x.val  = v;
      expq.push_back(x);
    end
    @(posedge clk);
    #1 host_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max, input string tag);
    int n = 0;
    while (expq.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    check({"drain_", tag}, expq.size(), 32'd0);
    expq.delete();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd(output int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cmd_valid !== 1'b1 && n < 200);
    check("cmd_wait", {31'd0, cmd_valid}, 32'd1);
    c = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    host_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expq.delete();
    dcyc.delete();
    ccyc.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, c1, c;
    rst = 1'b1; host_valid = 1'b0; host_type = 1'b0; host_cmd = '0;
    host_index = '0; host_value = '0; host_last = 1'b0; busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_host_ready", {31'd0, host_ready}, 32'd1);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_cmd_valid",  {31'd0, cmd_valid},  32'd0);
    check("rst_seq_err",    {31'd0, seq_err},    32'd0);
    check("rst_all_issued", {31'd0, all_issued}, 32'd0);

    // Data burst then spaced commands
    for (int i = 0; i < 12; i++) push(1'b0, 3'd0, 8'd0, 8'(8'h11 + i), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)  push(1'b1, 3'd1, 8'd2, 8'(8'h40 + i), 1'b0, 1'b1);
    wait_drain(100, "burst");
    check("burst_count", dcyc.size(), 32'd12);
    check("burst_contiguous", dcyc[11] - dcyc[0], 32'd11);
    check("cmd_count", ccyc.size(), 32'd3);
    check("cmd_spacing_0", ccyc[1] - ccyc[0], 32'd2);
    check("cmd_spacing_1", ccyc[2] - ccyc[1], 32'd2);

    // Busy handshake
    push(1'b1, 3'd3, 8'h10, 8'h50, 1'b0, 1'b1);
    push(1'b1, 3'd3, 8'h11, 8'h51, 1'b0, 1'b1);
    wait_cmd(c0);
    @(posedge clk);
    #1 busy = 1'b1;
    repeat (5) @(posedge clk);
    #1 busy = 1'b0;
    wait_cmd(c1);
    check("busy_release_gap", c1 - c0, 32'd7);
    wait_drain(50, "busy");

    // Full FIFO with output stalled
    busy = 1'b1;
    for (int i = 0; i < 16; i++) push(1'b1, 3'(i), 8'(i), 8'(8'h80 + i), 1'b0, 1'b1);
    check("full_ready_low", {31'd0, host_ready}, 32'd0);
    push(1'b1, 3'd7, 8'hFF, 8'hFF, 1'b0, 1'b0);
    check("full_17th_ready", {31'd0, host_ready}, 32'd0);
    busy = 1'b0;
    check("full_before_pop", {31'd0, host_ready}, 32'd0);
    @(posedge clk);
    #1 check("full_after_pop", {31'd0, host_ready}, 32'd1);
    wait_drain(200, "full");

    // Ordering error
    do_reset();
    push(1'b0, 3'd0, 8'd0, 8'h55, 1'b0, 1'b1);
    push(1'b1, 3'd2, 8'd3, 8'h60, 1'b0, 1'b1);
    push(1'b0, 3'd0, 8'd0, 8'hAA, 1'b0, 1'b0);
    wait_cmd(c);
    @(posedge clk);
    #1 check("seq_err_before", {31'd0, seq_err}, 32'd0);
    @(posedge clk);
    #1 check("seq_err_set", {31'd0, seq_err}, 32'd1);
    repeat (5) @(posedge clk);
    #1 check("seq_err_sticky", {31'd0, seq_err}, 32'd1);
    wait_drain(50, "order");

    // Last marker
    push(1'b1, 3'd4, 8'd5, 8'h70, 1'b1, 1'b1);
    wait_cmd(c);
    check("all_issued_at_pulse", {31'd0, all_issued}, 32'd0);
    @(posedge clk);
    #1 check("all_issued_rise", {31'd0, all_issued}, 32'd1);
    push(1'b0, 3'd0, 8'd0, 8'h33, 1'b0, 1'b0);
    push(1'b1, 3'd5, 8'd6, 8'h71, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1 check("all_issued_held", {31'd0, all_issued}, 32'd1);
    check("end_no_output", expq.size(), 32'd0);

    // Reset during the 5th data_valid
    do_reset();
    for (int i = 0; i < 6; i++) begin
      host_type = 1'b0; host_cmd = '0; host_index = '0; host_last = 1'b0;
      host_value = 8'(8'h21 + i);
      host_valid = 1'b1;
      if (i < 5) expq.push_back({1'b0, 3'd0, 8'd0, 8'(8'h21 + i)});
      @(posedge clk);
      #1;
    end
    host_valid = 1'b0;
    rst = 1'b1;
    check("burst_5th_valid", {31'd0, data_valid}, 32'd1);
    check("burst_5th_data", {24'd0, data}, 32'h25);
    @(posedge clk);
    #1;
    check("rst_mid_dvalid", {31'd0, data_valid}, 32'd0);
    check("rst_mid_data",   {24'd0, data}, 32'd0);
    check("rst_mid_cvalid", {31'd0, cmd_valid}, 32'd0);
    check("rst_mid_ready",  {31'd0, host_ready}, 32'd1);
    check("rst_mid_seqerr", {31'd0, seq_err}, 32'd0);
    check("rst_mid_alliss", {31'd0, all_issued}, 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("rst_mid_no_stale", expq.size(), 32'd0);
    push(1'b0, 3'd0, 8'd0, 8'h99, 1'b0, 1'b1);
    wait_drain(20, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
